bin2seg_multi: RTL and testbench
================================

Name: bin2seg_multi

Overview:
- Parametrised successor to the two-digit game-score decoder.
- Accepts an unsigned binary value through a valid/ready handshake and converts it to BCD sequentially (shift-and-add-3, one bit per clock).
- Drives DIGITS active-low 7-segment patterns, held stable between updates.
- Sits between the game FSM (score/level counters) and the board HEX displays; replaces per-width hand-written case tables.

Parameters:
- BIN_W, 6, width of binary input value.
- DIGITS, 2, number of decimal digits driven (1..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- valid_i  input  1  request: value_i is presented for conversion.
- value_i  input  BIN_W  unsigned binary value.
- ready_o  output  1  high when the block accepts a request (IDLE).
- done_o  output  1  one-cycle pulse when seg_o updates.
- ovf_o  output  1  registered; high when the last accepted value exceeds 10^DIGITS-1.
- seg_o  output  7*DIGITS  active-low segments; digit k at bits [7k+6:7k], k=0 is units; bit order per digit: bit0=a ... bit6=g.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE, ready_o=1, done_o=0, ovf_o=0.
  - seg_o all ones (all segments off).
  - Internal shift and BCD registers cleared.
- Handshake:
  - Transfer occurs on a rising edge where valid_i && ready_o.
  - value_i is captured into the shift register on that edge.
  - valid_i while ready_o=0 is ignored; no queueing.
- States:
  - IDLE: ready_o=1. On transfer:
    - clear the BCD register (4*DIGITS bits);
    - load the bit counter with BIN_W;
    - set ovf_pend = (value_i > 10^DIGITS-1), compared at full width;
    - go to SHIFT.
  - SHIFT: ready_o=0. Each cycle:
    - add 3 to every BCD nibble >=5;
    - shift {bcd, shreg} left by one; the MSB of shreg enters the BCD LSB; bits shifted out of the BCD MSB are discarded;
    - decrement the counter.
    - After BIN_W cycles, go to UPDATE.
  - UPDATE: ready_o=0.
    - seg_o <= patterns from the BCD nibbles, or the dash pattern (~7'b1000000) on every digit if ovf_pend.
    - ovf_o <= ovf_pend.
    - done_o=1 for this cycle only.
    - Next state IDLE.
- Latency: transfer edge to seg_o/done_o valid = BIN_W+1 edges. Minimum request spacing = BIN_W+2 cycles.
- seg_o holds its previous value throughout SHIFT (no flicker, no intermediate digits visible).
- Digit patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Nibble >9 cannot occur for non-overflow values. The decoder still maps it to all-off.
- Boundary values:
  - 0 → all digits "0".
  - 10^DIGITS-1 → all "9", ovf_o=0.
  - 10^DIGITS → dashes, ovf_o=1.
- BIN_W smaller than needed for DIGITS is legal: upper digits show "0". BIN_W larger is legal: overflow detection covers the excess.
- Reset during SHIFT/UPDATE aborts the conversion: no done_o pulse, seg_o blanked, next cycle ready_o=1.

Optional Feature:
- Macro BIN2SEG_LZ_BLANK_EN:
  - Defined: leading-zero blanking. Every digit k>0 whose nibble and all higher nibbles are zero shows all-off (1111111). Digit 0 always displays. Dashes are unaffected.
  - Undefined: all digits always display, including leading "0".

Decomposition:
- Package bin2seg_pkg:
  - SEG_DIGIT[0:9] constant array (active-low patterns);
  - SEG_OFF=7'h7F; SEG_DASH=7'b0111111;
  - state enum typedef {IDLE, SHIFT, UPDATE};
  - function pow10(n) for the overflow limit.
- Sub-module seg7_nibble (combinational nibble → active-low pattern, blank input), instantiated DIGITS times via generate.

Test Plan (default BIN_W=6, DIGITS=2 unless noted):
- Reset 3 cycles, then release → seg_o=14'h3FFF, ready_o=1, done_o=0, ovf_o=0.
- valid_i=1, value_i=23 for one cycle → ready_o=0 for 7 cycles; done_o pulses 7 edges after transfer; seg_o[13:7]=0100100, seg_o[6:0]=0110000.
- value_i=0 → both digits 1000000 (macro undefined); with BIN2SEG_LZ_BLANK_EN, seg_o[13:7]=1111111, seg_o[6:0]=1000000.
- BIN_W=7: value_i=99 → both 0010000, ovf_o=0; then value_i=100 → both 0111111, ovf_o=1.
- Hold valid_i=1 continuously with value_i=5 then 42 → the value changes while busy and is ignored; next transfer only when ready_o=1; exactly one done_o per transfer; display 05 then 42.
- Assert rst 3 cycles after a transfer of 57 → no done_o, seg_o=3FFF the next cycle, ready_o=1; a new request of 12 then converts correctly.

Source files
------------

// File: rtl/bin2seg_pkg.sv
// bin2seg_pkg: shared segment patterns, FSM state type and power-of-ten helper.
// Contents: SEG_DIGIT (active-low 0..9, bit0=a..bit6=g), SEG_OFF, SEG_DASH,
//           state_t {IDLE, SHIFT, UPDATE}, pow10(n).
package bin2seg_pkg;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction
endpackage

// File: rtl/bin2seg_multi_seg7_nibble.sv
// seg7_nibble: combinational BCD nibble to active-low 7-segment pattern.
// Ports: i_nib (BCD nibble), i_blank (force all-off), o_seg (bit0=a..bit6=g).
module seg7_nibble
    import bin2seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    // Nibbles above 9 only arise from non-BCD input; show them blank.
    assign o_seg = (i_blank || i_nib > 4'd9) ? SEG_OFF : SEG_DIGIT[i_nib];
endmodule

// File: rtl/bin2seg_multi.sv
// bin2seg_multi: valid/ready binary to multi-digit active-low 7-segment driver.
// Ports: clk, rst (sync, active-high), valid_i/value_i (request), ready_o (idle),
//        done_o (1-cycle update pulse), ovf_o (value > 10^DIGITS-1),
//        seg_o (digit k at [7k+6:7k], k=0 units).
// Option: define BIN2SEG_LZ_BLANK_EN to blank leading zero digits.
module bin2seg_multi
    import bin2seg_pkg::*;
#(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [BIN_W-1:0]      value_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic [7*DIGITS-1:0]   seg_o
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

    state_t              r_state;
    logic [BIN_W-1:0]    r_shreg;
    logic [BW-1:0]       r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf_pend;
    logic                r_done;
    logic                r_ovf;
    logic [7*DIGITS-1:0] r_seg;
    logic [BW-1:0]       w_adj;
    logic [7*DIGITS-1:0] w_seg;
    logic [DIGITS-1:0]   w_blank;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dig
            assign w_adj[4*k+:4] = (r_bcd[4*k+:4] >= 4'd5) ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
`ifdef BIN2SEG_LZ_BLANK_EN
            // A digit is a leading zero when it and every higher nibble are zero.
            if (k == 0) begin : g_units
                assign w_blank[k] = 1'b0;
            end else begin : g_upper
                assign w_blank[k] = r_bcd[BW-1:4*k] == '0;
            end
`else
            assign w_blank[k] = 1'b0;
`endif
            seg7_nibble u_nib (
                .i_nib   (r_bcd[4*k+:4]),
                .i_blank (w_blank[k]),
                .o_seg   (w_seg[7*k+:7])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_seg      <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (valid_i) begin
                    r_shreg    <= value_i;
                    r_bcd      <= '0;
                    r_cnt      <= CW'(BIN_W);
                    r_ovf_pend <= 64'(value_i) > LIMIT;
                    r_state    <= SHIFT;
                end
                SHIFT: begin
                    // Digits that overflow out of the top nibble are dropped; ovf covers them.
                    r_bcd   <= BW'({w_adj, r_shreg[BIN_W-1]});
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= UPDATE;
                end
                UPDATE: begin
                    r_seg   <= r_ovf_pend ? {DIGITS{SEG_DASH}} : w_seg;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o = r_state == IDLE;
    assign done_o  = r_done;
    assign ovf_o   = r_ovf;
    assign seg_o   = r_seg;
endmodule

// File: tb/tb_bin2seg_multi.sv
// tb_bin2seg_multi: randomized self-checking bench against a decimal reference model.
module tb_bin2seg_multi;
    localparam int BIN_W  = 7;
    localparam int DIGITS = 2;
    localparam int LIM    = 10 ** DIGITS - 1;
`ifdef BIN2SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid_i = 1'b0;
    logic [BIN_W-1:0]    value_i = '0;
    logic                ready_o;
    logic                done_o;
    logic                ovf_o;
    logic [7*DIGITS-1:0] seg_o;
    int                  n_cmp = 0;
    int                  n_bad = 0;

    always #5 clk = ~clk;

    bin2seg_multi #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .value_i (value_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .ovf_o   (ovf_o),
        .seg_o   (seg_o)
    );

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] model_seg(input int v);
        logic [7*DIGITS-1:0] s;
        int p;
        p = 1;
        s = '1;
        if (v > LIM) return {DIGITS{7'b0111111}};
        for (int d = 0; d < DIGITS; d++) begin
            s[7*d+:7] = (LZ && d > 0 && v / p == 0) ? 7'h7F : digit_pat((v / p) % 10);
            p = p * 10;
        end
        return s;
    endfunction

    task automatic send(input int v, output int lat, output int rlow, output int flick);
        logic [7*DIGITS-1:0] prev;
        @(negedge clk);
        prev    = seg_o;
        valid_i = 1'b1;
        value_i = v[BIN_W-1:0];
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        rlow = 0;
        flick = 0;
        while (!done_o && lat < 40) begin
            if (!ready_o) rlow++;
            if (seg_o !== prev) flick++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (seg_o !== '1) begin n_bad++; $display("FAIL reset_seg: got %h expected %h", seg_o, {7*DIGITS{1'b1}}); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
    endtask

    task automatic test_basic();
        int lat, rlow, flick;
        send(23, lat, rlow, flick);
        n_cmp++; if (lat !== BIN_W + 1) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, BIN_W + 1); end
        n_cmp++; if (rlow !== BIN_W + 1) begin n_bad++; $display("FAIL basic_busy: got %0d expected %0d", rlow, BIN_W + 1); end
        n_cmp++; if (flick !== 0) begin n_bad++; $display("FAIL basic_hold: got %0d changes expected 0", flick); end
        n_cmp++; if (seg_o !== model_seg(23)) begin n_bad++; $display("FAIL basic_seg: got %h expected %h", seg_o, model_seg(23)); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b expected 0", ovf_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b expected 1", ready_o); end
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b expected 0", done_o); end
    endtask

    task automatic test_boundary();
        int vals [6] = '{0, LIM, LIM + 1, 2 ** BIN_W - 1, 9, 10};
        int lat, rlow, flick;
        foreach (vals[i]) begin
            send(vals[i], lat, rlow, flick);
            n_cmp++; if (seg_o !== model_seg(vals[i])) begin n_bad++; $display("FAIL boundary_seg v=%0d: got %h expected %h", vals[i], seg_o, model_seg(vals[i])); end
            n_cmp++; if (ovf_o !== (vals[i] > LIM)) begin n_bad++; $display("FAIL boundary_ovf v=%0d: got %b expected %b", vals[i], ovf_o, vals[i] > LIM); end
        end
    endtask

    task automatic test_random();
        int v, lat, rlow, flick;
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 2 ** BIN_W - 1));
            send(v, lat, rlow, flick);
            n_cmp++; if (seg_o !== model_seg(v)) begin n_bad++; $display("FAIL random_seg v=%0d: got %h expected %h", v, seg_o, model_seg(v)); end
            n_cmp++; if (ovf_o !== (v > LIM)) begin n_bad++; $display("FAIL random_ovf v=%0d: got %b expected %b", v, ovf_o, v > LIM); end
            n_cmp++; if (flick !== 0 || lat !== BIN_W + 1) begin n_bad++; $display("FAIL random_timing v=%0d: got lat %0d changes %0d expected lat %0d changes 0", v, lat, flick, BIN_W + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int ndone, t1, t2, extra;
        logic [7*DIGITS-1:0] s1, s2;
        ndone = 0; t1 = 0; t2 = 0; extra = 0; s1 = '0; s2 = '0;
        @(negedge clk);
        valid_i = 1'b1;
        value_i = BIN_W'(5);
        for (int c = 1; c <= 40 && ndone < 2; c++) begin
            @(negedge clk);
            if (c == 1) value_i = BIN_W'(42);
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin s1 = seg_o; t1 = c; end
                else begin s2 = seg_o; t2 = c; valid_i = 1'b0; end
            end
        end
        valid_i = 1'b0;
        repeat (BIN_W + 4) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        n_cmp++; if (ndone !== 2 || extra !== 0) begin n_bad++; $display("FAIL b2b_done_count: got %0d+%0d expected 2+0", ndone, extra); end
        n_cmp++; if (t1 !== BIN_W + 2) begin n_bad++; $display("FAIL b2b_first_time: got %0d expected %0d", t1, BIN_W + 2); end
        n_cmp++; if (t2 - t1 !== BIN_W + 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, BIN_W + 2); end
        n_cmp++; if (s1 !== model_seg(5)) begin n_bad++; $display("FAIL b2b_seg_first: got %h expected %h", s1, model_seg(5)); end
        n_cmp++; if (s2 !== model_seg(42)) begin n_bad++; $display("FAIL b2b_seg_second: got %h expected %h", s2, model_seg(42)); end
    endtask

    task automatic test_reset_abort();
        int lat, rlow, flick, nd;
        nd = 0;
        @(negedge clk);
        valid_i = 1'b1;
        value_i = BIN_W'(57);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (seg_o !== '1) begin n_bad++; $display("FAIL abort_seg: got %h expected %h", seg_o, {7*DIGITS{1'b1}}); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b expected 1", ready_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL abort_ovf: got %b expected 0", ovf_o); end
        if (done_o) nd++;
        rst = 1'b0;
        repeat (BIN_W + 4) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", nd); end
        send(12, lat, rlow, flick);
        n_cmp++; if (lat !== BIN_W + 1) begin n_bad++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, BIN_W + 1); end
        n_cmp++; if (seg_o !== model_seg(12)) begin n_bad++; $display("FAIL abort_next_seg: got %h expected %h", seg_o, model_seg(12)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
